spi_seq_arbiter: RTL and testbench

Wishbone-master sequencer sharing one `simple_spi_master_wb` instance between two byte-transfer requesters. Per granted request it programs the SPI master's CONFIG register when needed, writes the transmit byte to DATA, and waits for the transfer to finish. It then reads DATA back and returns the received byte with a done pulse. It sits between on-chip clients (e.g. housekeeping and user logic) and the SPI master's Wishbone slave port.

---
 rtl/spi_seq_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_seq_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_seq_arbiter.sv
// Two-requester Wishbone sequencer sharing one simple_spi_master_wb instance.
// Per granted byte: optional CONFIG write, DATA write, wait for the SPI
// transfer, DATA read, then a done pulse with the received byte.
module spi_seq_arbiter #(
  parameter logic [31:0] CFG_ADR     = 32'h2400_0000,
  parameter logic [31:0] DATA_ADR    = 32'h2400_0004,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned BUSY_WAIT   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        lock0_i,
  input  logic        lock1_i,
  input  logic [15:0] cfg0_i,
  input  logic [15:0] cfg1_i,
  input  logic [7:0]  tx0_i,
  input  logic [7:0]  tx1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [7:0]  rx_o,
  output logic        err_o,
  input  logic        spi_busy_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {
    StIdle, StArb, StCfgWr, StDatWr, StWaitBsy, StWaitIdle, StDatRd, StDone
  } state_e;

  localparam logic [7:0] AckLast = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] BsyLast = 8'(BUSY_WAIT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;     // requester currently (or last) granted
  logic        rr_q, rr_d;           // requester served last
  logic        hold_q, hold_d;       // owner keeps the grant for the next byte
  logic        gnt_q, gnt_d;
  logic        cache_vld_q, cache_vld_d;
  logic [15:0] cache_q, cache_d;
  logic        err_q, err_d;
  logic [7:0]  rx_q, rx_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic [7:0]  bsy_cnt_q, bsy_cnt_d;

  logic        grant;
  logic [15:0] cfg_gnt;
  logic [15:0] cfg_sel;
  logic [7:0]  tx_sel;
  logic        ack_ok;
  logic        ack_to;
  logic        unused_dat;

  assign unused_dat = ^wbm_dat_i[31:8];

  // State and registered bus outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      rr_q        <= 1'b1;
      hold_q      <= 1'b0;
      gnt_q       <= 1'b0;
      cache_vld_q <= 1'b0;
      cache_q     <= 16'h0;
      err_q       <= 1'b0;
      rx_q        <= 8'h00;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      ack_cnt_q   <= 8'h0;
      bsy_cnt_q   <= 8'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      cache_vld_q <= cache_vld_d;
      cache_q     <= cache_d;
      err_q       <= err_d;
      rx_q        <= rx_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      ack_cnt_q   <= ack_cnt_d;
      bsy_cnt_q   <= bsy_cnt_d;
    end
  end

  // Sequencer next-state, arbitration and bus access control.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    cache_vld_d = cache_vld_q;
    cache_d     = cache_q;
    err_d       = err_q;
    rx_d        = rx_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    ack_cnt_d   = cyc_q ? ack_cnt_q + 8'd1 : 8'd0;
    bsy_cnt_d   = 8'd0;

    if (hold_q)                grant = owner_q;
    else if (req0_i && req1_i) grant = ~rr_q;
    else                       grant = req1_i;
    cfg_gnt = grant ? cfg1_i : cfg0_i;
    cfg_sel = owner_q ? cfg1_i : cfg0_i;
    tx_sel  = owner_q ? tx1_i : tx0_i;
    ack_ok  = cyc_q & wbm_ack_i;
    ack_to  = cyc_q & ~wbm_ack_i & (ack_cnt_q == AckLast);

    unique case (state_q)
      StIdle: begin
        // A held grant only lets its owner back in.
        if (hold_q ? (owner_q ? req1_i : req0_i) : (req0_i | req1_i)) state_d = StArb;
      end
      StArb: begin
        owner_d = grant;
        gnt_d   = 1'b1;
        state_d = (!cache_vld_q || cfg_gnt != cache_q) ? StCfgWr : StDatWr;
      end
      StCfgWr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = CFG_ADR;
          dat_d = {16'h0, cfg_sel};
        end else if (ack_ok) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = 32'h0;
          dat_d       = 32'h0;
          cache_vld_d = 1'b1;
          cache_d     = dat_q[15:0];
          state_d     = StDatWr;
        end
      end
      StDatWr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = DATA_ADR;
          dat_d = {24'h0, tx_sel};
        end else if (ack_ok) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = 32'h0;
          dat_d   = 32'h0;
          state_d = StWaitBsy;
        end
      end
      StWaitBsy: begin
        // A short transfer may finish before busy is ever seen.
        bsy_cnt_d = bsy_cnt_q + 8'd1;
        if (spi_busy_i) begin
          bsy_cnt_d = 8'd0;
          state_d   = StWaitIdle;
        end else if (bsy_cnt_q == BsyLast) begin
          bsy_cnt_d = 8'd0;
          state_d   = StDatRd;
        end
      end
      StWaitIdle: begin
        if (!spi_busy_i) state_d = StDatRd;
      end
      StDatRd: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = DATA_ADR;
          dat_d = 32'h0;
        end else if (ack_ok) begin
          cyc_d   = 1'b0;
          adr_d   = 32'h0;
          rx_d    = wbm_dat_i[7:0];
          state_d = StDone;
        end
      end
      StDone: begin
        rr_d    = owner_q;
        hold_d  = ~err_q & (owner_q ? lock1_i : lock0_i);
        gnt_d   = hold_d;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abandon a stalled access; the SPI master state is then unknown.
    if (ack_to) begin
      cyc_d       = 1'b0;
      we_d        = 1'b0;
      adr_d       = 32'h0;
      dat_d       = 32'h0;
      err_d       = 1'b1;
      rx_d        = 8'hFF;
      cache_vld_d = 1'b0;
      hold_d      = 1'b0;
      state_d     = StDone;
    end
  end

  assign gnt0_o    = gnt_q & ~owner_q;
  assign gnt1_o    = gnt_q & owner_q;
  assign done0_o   = (state_q == StDone) & ~owner_q;
  assign done1_o   = (state_q == StDone) & owner_q;
  assign err_o     = (state_q == StDone) & err_q;
  assign rx_o      = rx_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_spi_seq_arbiter.sv
// Directed bench for spi_seq_arbiter with a zero-wait Wishbone slave and a
// simple SPI busy model.
module tb_spi_seq_arbiter;

  localparam logic [31:0] CfgAdr  = 32'h2400_0000;
  localparam logic [31:0] DataAdr = 32'h2400_0004;

  typedef struct {
    logic        r0, r1, l0, l1;
    logic [15:0] c0, c1;
    logic [7:0]  t0, t1;
    logic [31:0] rd;
    int          bl;
    int          eid;
    logic        ecw;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic [15:0] cfg0 = 0, cfg1 = 0;
  logic [7:0]  tx0 = 0, tx1 = 0;
  logic        gnt0, gnt1, done0, done1, err;
  logic [7:0]  rx;
  logic        spi_busy;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic [31:0] rd_data = 32'h0;
  logic        ack = 1'b0;

  int   busy_len = 0;
  int   busy_cnt = 0;
  logic no_ack_dw = 1'b0;
  acc_t log_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   overlap = 0;
  int   prot = 0;
  int   cyc_len = 0;
  int   last_cyc_len = 0;
  logic p_cyc = 1'b0, p_ack = 1'b0;
  logic [64:0] p_sig = '0;

  logic [7:0] s_rx;
  logic       s_err;
  logic [1:0] s_gnt;

  vec_t vt[13];

  always #5 clk = ~clk;

  assign spi_busy = (busy_cnt != 0);

  spi_seq_arbiter dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req0_i     (req0),
    .req1_i     (req1),
    .lock0_i    (lock0),
    .lock1_i    (lock1),
    .cfg0_i     (cfg0),
    .cfg1_i     (cfg1),
    .tx0_i      (tx0),
    .tx1_i      (tx1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .done0_o    (done0),
    .done1_o    (done1),
    .rx_o       (rx),
    .err_o      (err),
    .spi_busy_i (spi_busy),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat),
    .wbm_dat_i  (rd_data),
    .wbm_ack_i  (ack)
  );

  // Slave: ack one cycle after stb, log every acked access, start SPI busy on DATA writes.
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (!rst && cyc && stb && !ack && !(no_ack_dw && we && adr == DataAdr)) begin
      ack <= 1'b1;
      log_q.push_back({we, adr, dat});
      if (we && adr == DataAdr) busy_cnt <= busy_len;
    end else begin
      ack <= 1'b0;
    end
  end

  // Bus protocol and grant exclusivity monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 && gnt1) overlap <= overlap + 1;
      if (cyc) begin
        if (sel != 4'hF || !stb) prot <= prot + 1;
        if (p_cyc && !p_ack && {we, adr, dat} != p_sig) prot <= prot + 1;
        if (p_cyc && p_ack) prot <= prot + 1;
        cyc_len <= cyc_len + 1;
      end else begin
        if (stb || we || sel != 4'h0 || adr != 32'h0 || dat != 32'h0) prot <= prot + 1;
        if (cyc_len != 0) last_cyc_len <= cyc_len;
        cyc_len <= 0;
      end
    end
    p_cyc <= cyc;
    p_ack <= ack;
    p_sig <= {we, adr, dat};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
    cfg0 = v.c0; cfg1 = v.c1; tx0 = v.t0; tx1 = v.t1;
    rd_data = v.rd; busy_len = v.bl;
  endtask

  task automatic wait_done(input int budget, output int id);
    id = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        id    = done1 ? 1 : 0;
        s_rx  = rx;
        s_err = err;
        s_gnt = {gnt1, gnt0};
        break;
      end
    end
  endtask

  // One full byte service; leaves time just after the posedge ending DONE.
  task automatic service(input vec_t v, input string name);
    int          base, id, ncfg, ndw, nrd;
    logic [31:0] cfgv, dwv;
    base = log_q.size();
    ncfg = 0; ndw = 0; nrd = 0; cfgv = 0; dwv = 0;
    apply(v);
    wait_done(300, id);
    chk({name, " done id"}, 32'(id), 32'(v.eid));
    chk({name, " rx"}, {24'h0, s_rx}, {24'h0, v.rd[7:0]});
    chk({name, " err"}, {31'h0, s_err}, 32'h0);
    chk({name, " gnt"}, {30'h0, s_gnt}, (v.eid == 1) ? 32'h2 : 32'h1);
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].we && log_q[i].adr == CfgAdr) begin
        ncfg++; cfgv = log_q[i].dat;
      end else if (log_q[i].we && log_q[i].adr == DataAdr) begin
        ndw++; dwv = log_q[i].dat;
      end else if (!log_q[i].we && log_q[i].adr == DataAdr) begin
        nrd++;
      end
    end
    chk({name, " cfg writes"}, 32'(ncfg), v.ecw ? 32'd1 : 32'd0);
    if (v.ecw) chk({name, " cfg value"}, cfgv, {16'h0, (v.eid == 1) ? v.c1 : v.c0});
    chk({name, " data writes"}, 32'(ndw), 32'd1);
    chk({name, " data value"}, dwv, {24'h0, (v.eid == 1) ? v.t1 : v.t0});
    chk({name, " reads"}, 32'(nrd), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   id, cnt;
    vec_t v;

    //         r0 r1 l0 l1 cfg0      cfg1      tx0    tx1    rd            bl eid ecw
    vt[0]  = '{1, 0, 0, 0, 16'h2002, 16'h0000, 8'hA5, 8'h00, 32'h0000_003C, 3, 0, 1};
    vt[1]  = '{1, 0, 0, 0, 16'h2002, 16'h0000, 8'h5B, 8'h00, 32'hFFFF_FF5A, 3, 0, 0};
    vt[2]  = '{1, 0, 0, 0, 16'h2102, 16'h0000, 8'h11, 8'h00, 32'h1234_5677, 2, 0, 1};
    vt[3]  = '{0, 1, 0, 0, 16'h0000, 16'h2102, 8'h00, 8'hC3, 32'h0000_0081, 0, 1, 0};
    vt[4]  = '{1, 1, 0, 0, 16'h2102, 16'h2102, 8'h10, 8'h20, 32'h0000_0001, 2, 0, 0};
    vt[5]  = '{1, 1, 0, 0, 16'h2102, 16'h2102, 8'h11, 8'h20, 32'h0000_0002, 2, 1, 0};
    vt[6]  = '{1, 1, 0, 0, 16'h2102, 16'h2102, 8'h12, 8'h21, 32'h0000_0003, 2, 0, 0};
    vt[7]  = '{1, 1, 0, 0, 16'h2102, 16'h2102, 8'h13, 8'h21, 32'h0000_0004, 2, 1, 0};
    vt[8]  = '{1, 1, 1, 0, 16'h2102, 16'h2102, 8'h31, 8'h41, 32'h0000_00E1, 2, 0, 0};
    vt[9]  = '{1, 1, 1, 0, 16'h2102, 16'h2102, 8'h32, 8'h41, 32'h0000_00E2, 2, 0, 0};
    vt[10] = '{1, 1, 0, 0, 16'h2102, 16'h2102, 8'h33, 8'h41, 32'h0000_00E3, 2, 0, 0};
    vt[11] = '{1, 1, 0, 0, 16'h2102, 16'h2102, 8'h34, 8'h41, 32'h0000_00E4, 2, 1, 0};
    vt[12] = '{0, 1, 0, 0, 16'h2102, 16'h2002, 8'h00, 8'h42, 32'h0000_00E5, 2, 1, 1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset cyc/stb/we", {29'h0, cyc, stb, we}, 32'h0);
    chk("reset sel", {28'h0, sel}, 32'h0);
    chk("reset adr", adr, 32'h0);
    chk("reset dat", dat, 32'h0);
    chk("reset gnt/done/err", {27'h0, gnt0, gnt1, done0, done1, err}, 32'h0);
    chk("reset rx", {24'h0, rx}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) service(vt[i], $sformatf("vec%0d", i));

    // Slave never acks the DATA write
    no_ack_dw = 1'b1;
    v = '{1, 0, 0, 0, 16'h2102, 16'h0000, 8'h99, 8'h00, 32'h0000_0055, 2, 0, 1};
    apply(v);
    wait_done(400, id);
    chk("timeout done id", 32'(id), 32'd0);
    chk("timeout err", {31'h0, s_err}, 32'h1);
    chk("timeout rx", {24'h0, s_rx}, 32'h0000_00FF);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    no_ack_dw = 1'b0;
    chk("timeout stb length", 32'(last_cyc_len), 32'd255);
    @(negedge clk);
    chk("err after done", {30'h0, err, done0}, 32'h0);
    @(posedge clk);
    #1;
    v = '{1, 0, 0, 0, 16'h2102, 16'h0000, 8'h77, 8'h00, 32'h0000_0066, 2, 0, 1};
    service(v, "after timeout");

    // Reset while waiting for the SPI transfer to finish
    v = '{1, 0, 0, 0, 16'h2102, 16'h0000, 8'h88, 8'h00, 32'h0000_0044, 60, 0, 0};
    apply(v);
    cnt = 0;
    while (!spi_busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("busy seen before reset", {31'h0, spi_busy}, 32'h1);
    repeat (5) @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("midrst cyc/stb", {30'h0, cyc, stb}, 32'h0);
    chk("midrst gnt/done/err", {28'h0, gnt0, gnt1, done0, err}, 32'h0);
    chk("midrst rx", {24'h0, rx}, 32'h0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || done1) cnt++;
    end
    chk("no done after reset", 32'(cnt), 32'd0);
    for (int i = 0; i < 100 && spi_busy; i++) @(negedge clk);
    @(posedge clk);
    #1;
    v = '{1, 0, 0, 0, 16'h2102, 16'h0000, 8'h5C, 8'h00, 32'h0000_00C5, 2, 0, 1};
    service(v, "after reset");

    apply('{0, 0, 0, 0, 16'h0, 16'h0, 8'h0, 8'h0, 32'h0, 0, 0, 0});
    repeat (3) @(negedge clk);
    chk("grant overlap count", 32'(overlap), 32'd0);
    chk("bus protocol violations", 32'(prot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
